// File: rtl/qam_pkg.sv
// Shared types, level constants and mapping helpers for the M-QAM modulator core.
// Levels are 3-bit signed; a symbol maps to one I and one Q level.
package qam_pkg;

  typedef logic signed [2:0] level_t;

  typedef struct packed {
    level_t i;
    level_t q;
  } iq_t;

  localparam level_t LVL_M3 = -3'sd3;
  localparam level_t LVL_M1 = -3'sd1;
  localparam level_t LVL_P1 = 3'sd1;
  localparam level_t LVL_P3 = 3'sd3;

  // Gray order along the axis: 00, 01, 11, 10 -> -3, -1, +1, +3.
  function automatic level_t gray_level(input logic [1:0] code);
    case (code)
      2'b00:   return LVL_M3;
      2'b01:   return LVL_M1;
      2'b11:   return LVL_P1;
      default: return LVL_P3;
    endcase
  endfunction

  function automatic level_t qpsk_level(input logic b);
    return b ? LVL_M1 : LVL_P1;
  endfunction

  // Word is right-aligned; for QPSK only bits [1:0] carry data.
  function automatic iq_t map_word(input logic [3:0] word, input int bits_per_sym);
    iq_t r;
    if (bits_per_sym == 4) begin
      r.i = gray_level(word[3:2]);
      r.q = gray_level(word[1:0]);
    end else begin
      r.i = qpsk_level(word[1]);
      r.q = qpsk_level(word[0]);
    end
    return r;
  endfunction

  // Normalising shift keeps the mixed output inside SAMPLE_W.
  function automatic int mix_shift(input int bits_per_sym);
    return (bits_per_sym == 4) ? 3 : 1;
  endfunction

  function automatic bit bits_legal(input int bits_per_sym);
    return (bits_per_sym == 2) || (bits_per_sym == 4);
  endfunction

endpackage

// File: rtl/qam_bit_collector.sv
// Serial-to-parallel symbol collector with valid/ready handshake.
// Holds a full word (ready low) until the symbol timer consumes it.
module qam_bit_collector
  import qam_pkg::*;
#(
  parameter int BITS_PER_SYM = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    bit_in,
  input  logic                    bit_valid,
  output logic                    bit_ready,
  input  logic                    consume,
  output logic [BITS_PER_SYM-1:0] word,
  output logic                    full
);

  localparam int CNT_W = $clog2(BITS_PER_SYM + 1);

  logic [CNT_W-1:0] count;
  logic             accept;

  assign full      = (count == CNT_W'(BITS_PER_SYM));
  assign bit_ready = rst && (count < CNT_W'(BITS_PER_SYM));
  assign accept    = bit_valid && bit_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      // NOTE: the shift register is a few flops, so it is reset with the count; a true RAM would not be.
      word  <= '0;
    end else if (consume) begin
      count <= '0;
    end else if (accept) begin
      word  <= {word[BITS_PER_SYM-2:0], bit_in};
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/qam_mod_core.sv
// M-QAM modulator core: collects serial bits into Gray-mapped symbols, strobes the
// external sine/cosine LUT and mixes the active I/Q levels into one signed stream.
module qam_mod_core
  import qam_pkg::*;
#(
  parameter int SAMPLE_W        = 16,
  parameter int BITS_PER_SYM    = 2,
  parameter int SAMPLES_PER_SYM = 16,
  parameter int PRESCALE        = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       bit_in,
  input  logic                       bit_valid,
  output logic                       bit_ready,
  input  logic signed [SAMPLE_W-1:0] sine_in,
  input  logic signed [SAMPLE_W-1:0] cosine_in,
  output logic                       sample_en,
  output logic signed [SAMPLE_W-1:0] signal_out,
  output logic                       signal_valid,
  output logic signed [2:0]          i_level,
  output logic signed [2:0]          q_level,
  output logic                       sym_strobe,
  output logic                       underrun
);

  localparam int ACC_W = SAMPLE_W + 4;
  localparam int SHIFT = mix_shift(BITS_PER_SYM);
  localparam int PRE_W = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
  localparam int SPS_W = $clog2(SAMPLES_PER_SYM);

  if (!bits_legal(BITS_PER_SYM)) begin : g_bad_bits
    $error("qam_mod_core: BITS_PER_SYM must be 2 (QPSK) or 4 (16-QAM)");
  end
  if (SAMPLES_PER_SYM < 2) begin : g_bad_sps
    $error("qam_mod_core: SAMPLES_PER_SYM must be at least 2");
  end

  // Prescaler and sample counter
  logic [PRE_W-1:0] pre_cnt;
  logic             pre_hit;
  logic [SPS_W-1:0] samp_cnt;
  logic             boundary;

  assign pre_hit   = (pre_cnt == PRE_W'(PRESCALE));
  assign sample_en = rst && pre_hit;
  assign boundary  = sample_en && (samp_cnt == SPS_W'(SAMPLES_PER_SYM - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_cnt  <= '0;
      samp_cnt <= '0;
    end else begin
      pre_cnt <= pre_hit ? '0 : pre_cnt + PRE_W'(1);
      if (sample_en) samp_cnt <= boundary ? '0 : samp_cnt + SPS_W'(1);
    end
  end

  // Bit collection
  logic                    consume;
  logic                    full;
  logic [BITS_PER_SYM-1:0] word;

  qam_bit_collector #(
    .BITS_PER_SYM(BITS_PER_SYM)
  ) u_collector (
    .clk      (clk),
    .rst      (rst),
    .bit_in   (bit_in),
    .bit_valid(bit_valid),
    .bit_ready(bit_ready),
    .consume  (consume),
    .word     (word),
    .full     (full)
  );

  // Symbol load / underrun decision at each boundary
  iq_t  lvl_q, lvl_d;
  logic started, started_d;
  logic sym_d, und_d;

  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    lvl_d     = lvl_q;
    started_d = started;
    sym_d     = 1'b0;
    und_d     = 1'b0;
    consume   = 1'b0;
    if (boundary) begin
      if (full) begin
        lvl_d     = map_word(4'(word), BITS_PER_SYM);
        consume   = 1'b1;
        sym_d     = 1'b1;
        started_d = 1'b1;
      end else if (started) begin
        lvl_d = '0;
        und_d = 1'b1;
      end
    end
  end

  // Mixer works on the levels held before this edge's update.
  logic signed [ACC_W-1:0] i_ext, q_ext, sin_ext, cos_ext, sum;

  assign i_ext   = {{(ACC_W-3){lvl_q.i[2]}}, lvl_q.i};
  assign q_ext   = {{(ACC_W-3){lvl_q.q[2]}}, lvl_q.q};
  assign sin_ext = {{4{sine_in[SAMPLE_W-1]}}, sine_in};
  assign cos_ext = {{4{cosine_in[SAMPLE_W-1]}}, cosine_in};
  assign sum     = i_ext * cos_ext + q_ext * sin_ext;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lvl_q        <= '0;
      started      <= 1'b0;
      sym_strobe   <= 1'b0;
      underrun     <= 1'b0;
      signal_out   <= '0;
      signal_valid <= 1'b0;
    end else begin
      lvl_q        <= lvl_d;
      started      <= started_d;
      sym_strobe   <= sym_d;
      underrun     <= und_d;
      signal_valid <= sample_en;
      if (sample_en) signal_out <= SAMPLE_W'(sum >>> SHIFT);
    end
  end

  assign i_level = lvl_q.i;
  assign q_level = lvl_q.q;

endmodule

// File: tb/tb_qam_mod_core.sv
// Self-checking bench: a QPSK instance (PRESCALE=3) and a 16-QAM instance (PRESCALE=0),
// each compared every cycle against a queue-based behavioural model.
module tb_qam_mod_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [1:0]        rst, bit_in, bit_valid, bit_ready, sample_en, signal_valid, sym_strobe, underrun;
  logic signed [15:0] sine [2];
  logic signed [15:0] cosine [2];
  logic signed [15:0] signal_out [2];
  logic signed [2:0]  i_level [2];
  logic signed [2:0]  q_level [2];
  logic [1:0]        rand_samp;
  logic [1:0]        done;

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // which: 0 = sym_strobe, 1 = underrun, 2 = signal_valid
  task automatic wait_pulse(input int g, input int which, input string name);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if ((which == 0 && sym_strobe[g]) || (which == 1 && underrun[g]) ||
          (which == 2 && signal_valid[g])) return;
    end
    checks++;
    errors++;
    $display("FAIL %s: timeout waiting for pulse", name);
  endtask

  // Called and returns at posedge+1; keep leaves bit_valid high for back-to-back bits.
  task automatic send_bit(input int g, input logic b, input bit keep);
    bit_in[g]    = b;
    bit_valid[g] = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bit_ready[g]) begin
        @(posedge clk);
        #1;
        if (!keep) bit_valid[g] = 1'b0;
        return;
      end
    end
    checks++;
    errors++;
    bit_valid[g] = 1'b0;
    $display("FAIL send_bit i%0d: timeout waiting for bit_ready", g);
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int BITS = (g == 0) ? 2 : 4;
    localparam int P    = (g == 0) ? 3 : 0;
    localparam int SPS  = 4;
    localparam int SH   = (g == 0) ? 1 : 3;

    qam_mod_core #(
      .SAMPLE_W       (16),
      .BITS_PER_SYM   (BITS),
      .SAMPLES_PER_SYM(SPS),
      .PRESCALE       (P)
    ) dut (
      .clk         (clk),
      .rst         (rst[g]),
      .bit_in      (bit_in[g]),
      .bit_valid   (bit_valid[g]),
      .bit_ready   (bit_ready[g]),
      .sine_in     (sine[g]),
      .cosine_in   (cosine[g]),
      .sample_en   (sample_en[g]),
      .signal_out  (signal_out[g]),
      .signal_valid(signal_valid[g]),
      .i_level     (i_level[g]),
      .q_level     (q_level[g]),
      .sym_strobe  (sym_strobe[g]),
      .underrun    (underrun[g])
    );

    // Behavioural model: cycle index arithmetic plus a FIFO of accepted bits.
    int  n_pre, k_samp, m_i, m_q, e_sig;
    bit  m_started, e_sv, e_sym, e_und;
    bit  mq[$];
    int  gray_lut[4];

    initial begin
      gray_lut = '{-3, -1, 3, 1};
      n_pre = 0; k_samp = 0; m_i = 0; m_q = 0; e_sig = 0;
      m_started = 0; e_sv = 0; e_sym = 0; e_und = 0;
      forever begin
        @(posedge clk or negedge rst[g]);
        if (!rst[g]) begin
          n_pre = 0; k_samp = 0; m_i = 0; m_q = 0; e_sig = 0;
          m_started = 0; e_sv = 0; e_sym = 0; e_und = 0;
          mq.delete();
        end else begin
          bit sen, rdy;
          sen   = (n_pre == P);
          rdy   = (mq.size() < BITS);
          n_pre = sen ? 0 : n_pre + 1;
          e_sv  = sen;
          e_sym = 0;
          e_und = 0;
          if (sen) begin
            e_sig = (m_i * int'(cosine[g]) + m_q * int'(sine[g])) >>> SH;
            if (k_samp == SPS - 1) begin
              if (mq.size() == BITS) begin
                if (BITS == 2) begin
                  m_i = mq[0] ? -1 : 1;
                  m_q = mq[1] ? -1 : 1;
                end else begin
                  m_i = gray_lut[{mq[0], mq[1]}];
                  m_q = gray_lut[{mq[2], mq[3]}];
                end
                repeat (BITS) void'(mq.pop_front());
                e_sym = 1;
                m_started = 1;
              end else if (m_started) begin
                m_i = 0;
                m_q = 0;
                e_und = 1;
              end
            end
            k_samp = (k_samp + 1) % SPS;
          end
          if (bit_valid[g] && rdy) mq.push_back(bit_in[g]);
        end
      end
    end

    initial forever begin
      @(negedge clk);
      check($sformatf("i%0d bit_ready", g), bit_ready[g], rst[g] && (mq.size() < BITS));
      check($sformatf("i%0d sample_en", g), sample_en[g], rst[g] && (n_pre == P));
      check($sformatf("i%0d signal_valid", g), signal_valid[g], e_sv);
      check($sformatf("i%0d signal_out", g), signal_out[g], e_sig);
      check($sformatf("i%0d i_level", g), i_level[g], m_i);
      check($sformatf("i%0d q_level", g), q_level[g], m_q);
      check($sformatf("i%0d sym_strobe", g), sym_strobe[g], e_sym);
      check($sformatf("i%0d underrun", g), underrun[g], e_und);
    end

    initial forever begin
      @(posedge clk);
      #1;
      if (rand_samp[g]) begin
        sine[g]   = 16'(int'($urandom_range(65534)) - 32767);
        cosine[g] = 16'(int'($urandom_range(65534)) - 32767);
      end
    end
  end

  // QPSK instance: prescaler, mapping, underrun, backpressure, async reset.
  initial begin
    logic [6:0] lfsr;
    bit prbs[64];
    int n_und, n_sym;
    lfsr = 7'h5A;
    for (int i = 0; i < 64; i++) begin
      prbs[i] = lfsr[6];
      lfsr = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
    end
    rst[0] = 1'b1; bit_in[0] = 1'b0; bit_valid[0] = 1'b0; rand_samp[0] = 1'b0; done[0] = 1'b0;
    sine[0] = 16'sh4000; cosine[0] = 16'sh2000;
    #2 rst[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst[0] = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      check($sformatf("prescale sample_en c%0d", c), sample_en[0], (c % 4) == 0);
      check($sformatf("prescale signal_valid c%0d", c), signal_valid[0], (c % 4) == 1 && c > 1);
    end
    @(posedge clk); #1;
    send_bit(0, 1'b0, 0);
    send_bit(0, 1'b0, 0);
    wait_pulse(0, 0, "qpsk first load");
    @(posedge clk); #1;
    send_bit(0, 1'b1, 0);
    send_bit(0, 1'b1, 0);
    wait_pulse(0, 2, "qpsk +1+1 sample");
    check("qpsk +1+1 signal_out", signal_out[0], 32'sh3000);
    check("qpsk +1+1 model", g_inst[0].e_sig, 32'sh3000);
    check("qpsk +1 i_level", i_level[0], 1);
    wait_pulse(0, 0, "qpsk second load");
    @(posedge clk); #1;
    wait_pulse(0, 2, "qpsk -1-1 sample");
    check("qpsk -1-1 signal_out", signal_out[0], -12288);
    check("qpsk -1-1 q_level", q_level[0], -1);
    wait_pulse(0, 1, "underrun pulse");
    check("underrun i_level", i_level[0], 0);
    check("underrun q_level", q_level[0], 0);
    @(posedge clk); #1;
    wait_pulse(0, 2, "underrun sample");
    check("underrun signal_out", signal_out[0], 0);
    @(posedge clk); #1;
    send_bit(0, 1'b1, 0);
    send_bit(0, 1'b0, 0);
    wait_pulse(0, 0, "reload after underrun");
    check("reload i_level", i_level[0], -1);
    check("reload q_level", q_level[0], 1);
    @(posedge clk); #1;
    rand_samp[0] = 1'b1;
    for (int i = 0; i < 64; i++) send_bit(0, prbs[i], 1);
    bit_valid[0] = 1'b0;
    wait_pulse(0, 0, "prbs drain load");
    @(posedge clk); #1;
    send_bit(0, 1'b1, 0);
    #3 rst[0] = 1'b0;
    #1;
    check("async rst bit_ready", bit_ready[0], 0);
    check("async rst sample_en", sample_en[0], 0);
    check("async rst signal_out", signal_out[0], 0);
    check("async rst signal_valid", signal_valid[0], 0);
    check("async rst i_level", i_level[0], 0);
    check("async rst q_level", q_level[0], 0);
    check("async rst sym_strobe", sym_strobe[0], 0);
    check("async rst underrun", underrun[0], 0);
    repeat (2) @(posedge clk);
    #1 rst[0] = 1'b1;
    n_und = 0;
    n_sym = 0;
    repeat (40) begin
      @(negedge clk);
      n_und += int'(underrun[0]);
      n_sym += int'(sym_strobe[0]);
    end
    check("post-reset underrun count", n_und, 0);
    check("post-reset sym_strobe count", n_sym, 0);
    done[0] = 1'b1;
  end

  // 16-QAM instance: Gray mapping, then random traffic with gaps.
  initial begin
    rst[1] = 1'b1; bit_in[1] = 1'b0; bit_valid[1] = 1'b0; rand_samp[1] = 1'b0; done[1] = 1'b0;
    sine[1] = 16'sd1000; cosine[1] = 16'sd8000;
    #2 rst[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst[1] = 1'b1;
    send_bit(1, 1'b1, 0);
    send_bit(1, 1'b0, 0);
    send_bit(1, 1'b0, 0);
    send_bit(1, 1'b1, 0);
    wait_pulse(1, 0, "qam16 load 1001");
    check("qam16 1001 i_level", i_level[1], 3);
    check("qam16 1001 q_level", q_level[1], -1);
    @(posedge clk); #1;
    wait_pulse(1, 2, "qam16 1001 sample");
    check("qam16 1001 signal_out", signal_out[1], 2875);
    check("qam16 1001 model", g_inst[1].e_sig, 2875);
    @(posedge clk); #1;
    send_bit(1, 1'b0, 0);
    send_bit(1, 1'b0, 0);
    send_bit(1, 1'b1, 0);
    send_bit(1, 1'b1, 0);
    wait_pulse(1, 0, "qam16 load 0011");
    check("qam16 0011 i_level", i_level[1], -3);
    check("qam16 0011 q_level", q_level[1], 1);
    @(posedge clk); #1;
    wait_pulse(1, 2, "qam16 0011 sample");
    check("qam16 0011 signal_out", signal_out[1], -2875);
    @(posedge clk); #1;
    rand_samp[1] = 1'b1;
    for (int c = 0; c < 800; c++) begin
      bit_valid[1] = (c < 400) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
      bit_in[1]    = 1'($urandom_range(1));
      @(posedge clk); #1;
    end
    bit_valid[1] = 1'b0;
    done[1] = 1'b1;
  end

  initial begin
    wait (done[0] && done[1]);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/qam_mod_core.md
Name: qam_mod_core

Overview:
Parametrised M-QAM modulator core: the successor to the fixed QPSK serial-to-parallel/mixer chain. It accepts a serial bit stream over a valid/ready handshake and groups it into symbols (QPSK or 16-QAM, Gray-mapped). It generates the sample strobe for the external sine/cosine LUT and mixes the current I/Q levels with the LUT samples into one signed output stream. Underrun is detected and flagged explicitly.

Parameters:
- SAMPLE_W, 16: width of sine_in, cosine_in, signal_out (signed two's complement).
- BITS_PER_SYM, 2: 2 = QPSK, 4 = 16-QAM; any other value is illegal (elaboration error).
- SAMPLES_PER_SYM, 16: carrier samples per symbol, >= 2.
- PRESCALE, 0: sample strobe every PRESCALE+1 clocks.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- bit_in  in  1  serial data bit, MSB of symbol first
- bit_valid  in  1  bit_in valid
- bit_ready  out  1  core accepts bit when bit_valid && bit_ready
- sine_in  in  SAMPLE_W  signed sine sample; valid in any cycle sample_en = 1
- cosine_in  in  SAMPLE_W  signed cosine sample; valid in any cycle sample_en = 1
- sample_en  out  1  one-cycle strobe; LUT advances address on it
- signal_out  out  SAMPLE_W  signed modulated sample
- signal_valid  out  1  one-cycle pulse; signal_out updated
- i_level  out  3  signed active I level (-3, -1, 0, +1, +3)
- q_level  out  3  signed active Q level
- sym_strobe  out  1  pulse: new symbol loaded
- underrun  out  1  pulse: symbol boundary with no complete symbol

Behaviour:
- Reset (rst = 0, async): all outputs 0; prescaler = 0; sample counter = 0; bit count = 0; levels = 0 (idle); started = 0. A partial symbol is discarded. Reset mid-operation gives the same state; there is no recovery of in-flight bits.
- Prescaler: counter runs 0..PRESCALE. sample_en = 1 in the cycle the counter equals PRESCALE; the counter then wraps to 0. PRESCALE = 0 gives sample_en every cycle.
- Bit collector: shift register plus count 0..BITS_PER_SYM.
  - bit_ready = (count < BITS_PER_SYM).
  - On accept: shift left, bit_in enters the LSB, count + 1.
  - When full, bit_ready stays low until the word is consumed.
- Sample counter: advances on sample_en over 0..SAMPLES_PER_SYM-1, then wraps. A boundary is a sample_en cycle with counter = SAMPLES_PER_SYM-1.
- At a boundary:
  - If count = BITS_PER_SYM: load the mapped levels, set count = 0, pulse sym_strobe, set started = 1.
  - Else if started = 1: levels = 0, pulse underrun; the partial bits are kept.
  - Else (no symbol yet since reset): levels stay 0, no pulse.
  - No simultaneous accept and load can occur, because ready is low when full.
- Mapping:
  - QPSK, word[1] -> I, word[0] -> Q: 0 -> +1, 1 -> -1.
  - 16-QAM, word[3:2] -> I, word[1:0] -> Q, Gray code: 00 -> -3, 01 -> -1, 11 -> +1, 10 -> +3.
- Mixing (in the sample_en cycle, using the levels held before that edge's update): sum = I*cosine_in + Q*sine_in at SAMPLE_W+4 bits.
  - signal_out = sum >>> SHIFT (arithmetic shift, floor), with SHIFT = 1 for QPSK and 3 for 16-QAM.
  - The result always fits SAMPLE_W, so no saturation logic is needed.
- Latency and symbol timing: signal_out and signal_valid are registered and appear one clock after sample_en. Each loaded symbol is used for exactly SAMPLES_PER_SYM samples, at counter values 0..SAMPLES_PER_SYM-1 after the load.
- i_level and q_level are the registered active levels.

Decomposition:
- Shared package qam_pkg holds:
  - level constants (LVL_M3, LVL_M1, LVL_P1, LVL_P3);
  - the Gray-map function;
  - the SHIFT function of BITS_PER_SYM;
  - the legal BITS_PER_SYM check.
- Sub-module qam_bit_collector: shift register, count and ready/accept handshake, with a consume input and word/full outputs.

Test Plan:
- Prescaler: PRESCALE=3, reset released -> sample_en high every 4th clk, first at clk 4 after release; signal_valid follows 1 clk later.
- QPSK map: BITS=2, SPS=4, bits 0,0 then 1,1; sine_in = 0x4000, cosine_in = 0x2000 -> levels (+1,+1) for 4 samples giving signal_out 0x3000, then (-1,-1) giving 0xD000.
- 16-QAM Gray map: BITS=4, word 1001 -> I = +3, Q = -1; cos = 8000, sin = 1000 -> signal_out = (24000 - 1000)>>>3 = 2875; word 0011 -> (-3,+1), out = -2875 with the same inputs.
- Underrun: after one symbol, hold bit_valid = 0 -> at the next boundary underrun pulses once, levels become 0 and signal_out = 0. Supplying 2 bits later -> load at the following boundary with sym_strobe.
- Backpressure: bit_valid held at 1 with BITS=2 -> bit_ready drops after 2 accepts and rises the cycle after the boundary load. No bit is lost or duplicated (check against a 64-bit PRBS reference).
- Async reset mid-symbol: assert rst = 0 with 1 bit collected -> all outputs 0 immediately (no clk edge needed). After release, the first boundary gives no underrun.
